grid_ctrl_axil_regfile: RTL and testbench

GRID_CTRL_AXIL_REGFILE -- requirements
Module: grid_ctrl_axil_regfile

---
 rtl/grid_ctrl_pkg.sv | 15 +
 rtl/grid_ctrl_reg_bank.sv | 55 +++++
 rtl/grid_ctrl_axil_regfile.sv | 202 ++++++++++++++++++++
 tb/tb_grid_ctrl_axil_regfile.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/grid_ctrl_pkg.sv
// Shared types for the grid control register file: write-FSM states and AXI response codes.
// No logic; no latency; no backpressure.
// Imported by grid_ctrl_axil_regfile and grid_ctrl_reg_bank.
package grid_ctrl_pkg;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_COMMIT = 2'd1,
        W_RESP   = 2'd2
    } wr_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/grid_ctrl_reg_bank.sv
// RW register storage with per-byte strobe merge and one-cycle write pulses.
// Latency: write lands on the edge ending the wr_en cycle; pulse is combinational with wr_en.
// Backpressure: none, a write is taken whenever wr_en is high.
module grid_ctrl_reg_bank
    import grid_ctrl_pkg::*;
#(
    parameter int DW       = 32,
    parameter int NUM_REGS = 16,
    parameter int NUM_RW   = 14,
    parameter int IDX_W    = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic [DW-1:0]            wr_data,
    input  logic [DW/8-1:0]          wr_strb,
    output logic [NUM_REGS*DW-1:0]   reg_q,
    output logic [NUM_REGS-1:0]      wr_pulse
);

    logic [DW-1:0] regs_q [NUM_REGS];
    logic [DW-1:0] regs_d [NUM_REGS];

    // Only RW indices match, so read-only and out-of-range writes fall through untouched.
    always_comb begin
        regs_d   = regs_q;
        wr_pulse = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            if (wr_en && wr_idx == IDX_W'(i)) begin
                wr_pulse[i] = 1'b1;
                for (int b = 0; b < DW/8; b++) begin
                    if (wr_strb[b]) begin
                        regs_d[i][b*8 +: 8] = wr_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_q[g*DW +: DW] = regs_q[g];
    end

endmodule

// File: rtl/grid_ctrl_axil_regfile.sv
// AXI4-Lite register file for grid control; GRID_CTRL_SLVERR_EN turns out-of-range accesses into SLVERR.
// Latency: write commits (BVALID + pulse) one cycle after AW and W are both latched; RDATA one cycle after AR.
// Backpressure: AW/W/AR READY drop after capture until BREADY/RREADY retire the response.
module grid_ctrl_axil_regfile
    import grid_ctrl_pkg::*;
#(
    parameter int  C_S_AXI_DATA_WIDTH = 32,
    parameter int  NUM_REGS           = 16,
    parameter int  NUM_RO             = 2,
    localparam int C_S_AXI_ADDR_WIDTH = $clog2(NUM_REGS) + $clog2(C_S_AXI_DATA_WIDTH/8) + 1
) (
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]                    reg_wr_pulse,
    input  logic [NUM_RO*C_S_AXI_DATA_WIDTH-1:0]   status_d
);

    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int OFS_W  = $clog2(DW/8);
    localparam int IDX_W  = $clog2(NUM_REGS) + 1;
    localparam int NUM_RW = NUM_REGS - NUM_RO;
    localparam logic [IDX_W-1:0] REG_LIM = IDX_W'(NUM_REGS);
`ifdef GRID_CTRL_SLVERR_EN
    localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
    localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

    wr_state_e          state_q, state_d;
    logic               aw_have_q, aw_have_d, w_have_q, w_have_d;
    logic [IDX_W-1:0]   aw_idx_q, aw_idx_d;
    logic [DW-1:0]      w_data_q, w_data_d;
    logic [DW/8-1:0]    w_strb_q, w_strb_d;
    logic               awready_q, awready_d, wready_q, wready_d;
    logic               bvalid_q, bvalid_d;
    logic [1:0]         bresp_q, bresp_d;
    logic               arready_q, arready_d, rvalid_q, rvalid_d;
    logic [DW-1:0]      rdata_q, rdata_d, rd_word;
    logic [1:0]         rresp_q, rresp_d;
    logic               aw_hs, w_hs, ar_hs;
    logic [IDX_W-1:0]   ar_idx;
    logic               unused_ok;

    assign aw_hs  = S_AXI_AWVALID && awready_q;
    assign w_hs   = S_AXI_WVALID && wready_q;
    assign ar_hs  = S_AXI_ARVALID && arready_q;
    assign ar_idx = S_AXI_ARADDR[OFS_W +: IDX_W];
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[OFS_W-1:0], S_AXI_ARADDR[OFS_W-1:0]};

    always_comb begin
        state_d   = state_q;
        aw_have_d = aw_have_q;
        w_have_d  = w_have_q;
        aw_idx_d  = aw_idx_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        case (state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_have_d = 1'b1;
                    aw_idx_d  = S_AXI_AWADDR[OFS_W +: IDX_W];
                end
                if (w_hs) begin
                    w_have_d = 1'b1;
                    w_data_d = S_AXI_WDATA;
                    w_strb_d = S_AXI_WSTRB;
                end
                if (aw_have_d && w_have_d) begin
                    state_d   = W_COMMIT;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    bresp_d   = (aw_idx_d >= REG_LIM) ? OOR_RESP : RESP_OKAY;
                end else begin
                    awready_d = !aw_have_d;
                    wready_d  = !w_have_d;
                end
            end
            W_COMMIT, W_RESP: begin
                aw_have_d = 1'b0;
                w_have_d  = 1'b0;
                if (S_AXI_BREADY) begin
                    state_d   = W_IDLE;
                    bvalid_d  = 1'b0;
                    bresp_d   = RESP_OKAY;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end else begin
                    state_d = W_RESP;
                end
            end
            default: state_d = W_IDLE;
        endcase
    end

    // Status is sampled in the AR handshake cycle; out-of-range indices read as zero.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            if (ar_idx == IDX_W'(i)) rd_word = reg_q[i*DW +: DW];
        end
        for (int i = 0; i < NUM_RO; i++) begin
            if (ar_idx == IDX_W'(NUM_RW + i)) rd_word = status_d[i*DW +: DW];
        end
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rvalid_d = rvalid_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_word;
            rresp_d  = (ar_idx >= REG_LIM) ? OOR_RESP : RESP_OKAY;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
        arready_d = !rvalid_d;
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q   <= W_IDLE;
            aw_have_q <= 1'b0;
            w_have_q  <= 1'b0;
            aw_idx_q  <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            aw_have_q <= aw_have_d;
            w_have_q  <= w_have_d;
            aw_idx_q  <= aw_idx_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    grid_ctrl_reg_bank #(
        .DW       (DW),
        .NUM_REGS (NUM_REGS),
        .NUM_RW   (NUM_RW),
        .IDX_W    (IDX_W)
    ) u_bank (
        .clk      (S_AXI_ACLK),
        .rst_n    (S_AXI_ARESETN),
        .wr_en    (state_q == W_COMMIT),
        .wr_idx   (aw_idx_q),
        .wr_data  (w_data_q),
        .wr_strb  (w_strb_q),
        .reg_q    (reg_q),
        .wr_pulse (reg_wr_pulse)
    );

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_grid_ctrl_axil_regfile.sv
// Bench for grid_ctrl_axil_regfile: directed cases plus randomized AXI-Lite traffic against an array model.
module tb_grid_ctrl_axil_regfile;

    localparam int DW = 32, NR = 16, NRO = 2, NRW = NR - NRO, AW = 7;
`ifdef GRID_CTRL_SLVERR_EN
    localparam logic [1:0] OOR = 2'b10;
`else
    localparam logic [1:0] OOR = 2'b00;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic [AW-1:0] awaddr, araddr;
    logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [3:0] wstrb;
    logic [1:0] bresp, rresp;
    logic [NR*DW-1:0] reg_q;
    logic [NR-1:0] pulse;
    logic [31:0] model [NR];
    logic [31:0] stat [NRO];
    logic [NRO*DW-1:0] status_d;
    int vec_cnt = 0, err_cnt = 0;

    assign status_d = {stat[1], stat[0]};
    always #5 clk = ~clk;

    grid_ctrl_axil_regfile dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .reg_q(reg_q), .reg_wr_pulse(pulse), .status_d(status_d)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input int idx);
        if (idx < NRW) return model[idx];
        if (idx < NR) return stat[idx - NRW];
        return 32'h0;
    endfunction

    function automatic logic [1:0] exp_resp(input int idx);
        return (idx >= NR) ? OOR : 2'b00;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_readies", {awready, wready, arready}, 0);
        check("rst_pulse", pulse, 0);
        check("rst_rdata", rdata, 0);
        for (int i = 0; i < NRW; i++) check("rst_reg_q", reg_q[i*32 +: 32], 0);
        for (int i = 0; i < NR; i++) model[i] = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rel_readies_low", {awready, wready, arready}, 0);
        @(posedge clk); #1;
        check("rel_readies_high", {awready, wready, arready}, 3'b111);
    endtask

    // w_lead > 0: W shown that many cycles before AW; < 0: AW first.
    task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int w_lead, input int hold, input bit abort);
        int idx = int'(addr[AW-1:2]);
        int t = 0;
        int aw_start = (w_lead > 0) ? w_lead : 0;
        int w_start = (w_lead < 0) ? -w_lead : 0;
        bit aw_done = 0, w_done = 0, hs_aw, hs_w;
        logic [NR-1:0] ep = '0;
        logic [31:0] mask;
        while (!(aw_done && w_done) && t < 40) begin
            awvalid = !aw_done && t >= aw_start; awaddr = addr;
            wvalid = !w_done && t >= w_start; wdata = data; wstrb = strb;
            hs_aw = awvalid && awready;
            hs_w = wvalid && wready;
            @(posedge clk); #1;
            if (hs_aw) aw_done = 1;
            if (hs_w) w_done = 1;
            t++;
        end
        awvalid = 0; wvalid = 0;
        if (!(aw_done && w_done)) begin
            check("wr_accept_timeout", 0, 1);
            return;
        end
        if (idx < NRW) ep[idx] = 1'b1;
        check("bvalid_at_commit", bvalid, 1);
        check("bresp", bresp, exp_resp(idx));
        check("wr_pulse", pulse, ep);
        if (idx < NRW) begin
            mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
            model[idx] = (model[idx] & ~mask) | (data & mask);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("bvalid_hold", {bvalid, bresp}, {1'b1, exp_resp(idx)});
            check("pulse_after_commit", pulse, 0);
            check("no_accept_in_resp", {awready, wready}, 0);
        end
        if (abort) return;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check("bvalid_clear", bvalid, 0);
        if (idx < NRW) check("reg_q_word", reg_q[idx*32 +: 32], model[idx]);
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int hold);
        int idx = int'(addr[AW-1:2]);
        int n = 0;
        logic [31:0] ed;
        logic [1:0] er;
        arvalid = 1'b1; araddr = addr;
        while (!arready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!arready) begin
            check("ar_accept_timeout", 0, 1);
            arvalid = 1'b0;
            return;
        end
        ed = exp_rd(idx);
        er = exp_resp(idx);
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("rvalid", rvalid, 1);
        check("rdata", rdata, ed);
        check("rresp", rresp, er);
        for (int i = 0; i < hold; i++) begin
            stat[i % NRO] = $urandom;
            @(posedge clk); #1;
            check("r_hold", {rvalid, rresp, rdata}, {1'b1, er, ed});
            check("no_ar_while_rvalid", arready, 0);
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        check("rvalid_clear", rvalid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] a;
        rst_n = 0; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        stat[0] = 32'h1111_2222; stat[1] = 32'h0;
        do_reset();

        for (int i = 0; i < 4; i++) do_write(AW'(i*4), 32'(i+1), 4'hF, 0, 0, 0);
        for (int i = 0; i < 4; i++) do_read(AW'(i*4), 0);

        do_write(7'h10, 32'hA5A5_A5A5, 4'hF, 3, 1, 0);
        check("reg4_after_w_first", reg_q[4*32 +: 32], 32'hA5A5_A5A5);

        do_write(7'h00, 32'hFFFF_FFFF, 4'hF, -2, 0, 0);
        do_write(7'h00, 32'h1234_5678, 4'b0101, 0, 0, 0);
        check("strobe_merge", reg_q[31:0], 32'hFF34_FF78);
        do_write(7'h04, 32'h0, 4'h0, 0, 0, 0);

        stat[1] = 32'hDEAD_BEEF;
        do_write(7'h3C, 32'h0, 4'hF, 0, 0, 0);
        do_read(7'h3C, 2);
        stat[1] = 32'hDEAD_BEEF;
        do_read(7'h3C, 0);

        do_read(7'h40, 1);
        do_write(7'h44, 32'hFFFF_FFFF, 4'hF, 1, 1, 0);

        for (int it = 0; it < 80; it++) begin
            a = {5'($urandom_range(0, 31)), 2'($urandom)};
            if ($urandom_range(0, 3) == 0) stat[$urandom_range(0, NRO-1)] = $urandom;
            if ($urandom_range(0, 1) == 0)
                do_write(a, $urandom, 4'($urandom), int'($urandom_range(0, 6)) - 3,
                         int'($urandom_range(0, 3)), 0);
            else
                do_read(a, int'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 2*NR; i++) do_read(AW'(i*4), 0);

        do_write(7'h08, 32'hCAFE_F00D, 4'hF, 0, 10, 1);
        do_reset();
        check("reg2_cleared", reg_q[2*32 +: 32], 0);
        do_write(7'h08, 32'h0000_0005, 4'hF, 0, 1, 0);
        do_read(7'h08, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
